// File: rtl/hbm_wdata_stager_pkg.sv
// rtl/hbm_wdata_stager_pkg.sv - shared state type and default sizing for the HBM write-data stager
package hbm_wdata_stager_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 512;
  localparam int unsigned DEF_BURST_LEN  = 64;
  localparam int unsigned DEF_FIFO_DEPTH = 128;
  localparam int unsigned DEF_LEN_WIDTH  = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } stager_state_e;

endpackage

// File: rtl/hbm_wbuf_fifo.sv
// rtl/hbm_wbuf_fifo.sv - show-ahead beat buffer with asynchronous-read storage
module hbm_wbuf_fifo
  import hbm_wdata_stager_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned C_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [C_DATA_WIDTH-1:0]    push_data,
  input  logic                       pop,
  output logic [C_DATA_WIDTH-1:0]    pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(C_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(C_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(C_DEPTH);

  // Async-read array so the head entry is visible the cycle after it is written.
  logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hbm_wdata_stager.sv
// rtl/hbm_wdata_stager.sv - buffers upstream beats and releases them as gapless AXI write bursts
module hbm_wdata_stager
  import hbm_wdata_stager_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned C_BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned C_FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned C_LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                            aclk,
  input  logic                            areset_n,
  input  logic                            ctrl_start,
  input  logic [C_LEN_WIDTH-1:0]          ctrl_xfer_beats,
  output logic                            ctrl_done,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]         s_axis_tdata,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  output logic [C_DATA_WIDTH-1:0]         m_wdata,
  output logic [$clog2(C_FIFO_DEPTH):0]   occupancy,
  output logic                            busy
);

  localparam int unsigned OCC_W = $clog2(C_FIFO_DEPTH) + 1;
  localparam logic [C_LEN_WIDTH-1:0] BURST_BEATS = C_LEN_WIDTH'(C_BURST_LEN);
  localparam logic [C_LEN_WIDTH-1:0] ONE_BEAT    = C_LEN_WIDTH'(1);

  function automatic logic [C_LEN_WIDTH-1:0] burst_size(input logic [C_LEN_WIDTH-1:0] beats_left);
    return (beats_left < BURST_BEATS) ? beats_left : BURST_BEATS;
  endfunction

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) rst_sync_q <= '0;
    else           rst_sync_q <= rst_sync_d;
  end

  stager_state_e          state_q, state_d;
  logic [C_LEN_WIDTH-1:0] in_left_q, in_left_d;
  logic [C_LEN_WIDTH-1:0] out_left_q, out_left_d;
  logic [C_LEN_WIDTH-1:0] burst_left_q, burst_left_d;
  logic                   done_q, done_d;

  logic                   fifo_full, fifo_empty;
  logic [OCC_W-1:0]       fifo_count;
  logic [C_LEN_WIDTH-1:0] occ_ext;
  logic                   running, push, pop, gate_open;

  assign running = (state_q == ST_RUN);
  assign occ_ext = C_LEN_WIDTH'(fifo_count);

  assign s_axis_tready = running & ~fifo_full & (in_left_q != '0);
  // Once the whole remaining burst is buffered, pops only race pushes, so the gate cannot drop mid-burst.
  assign gate_open     = running & ~fifo_empty & (burst_left_q != '0) & (occ_ext >= burst_left_q);
  assign m_wvalid      = gate_open;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = gate_open & m_wready;

  assign ctrl_done = done_q;
  assign busy      = running;
  assign occupancy = fifo_count;

  always_comb begin
    state_d      = state_q;
    in_left_d    = in_left_q;
    out_left_d   = out_left_q;
    burst_left_d = burst_left_q;
    done_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          if (ctrl_xfer_beats == '0) begin
            done_d = 1'b1;
          end else begin
            in_left_d    = ctrl_xfer_beats;
            out_left_d   = ctrl_xfer_beats;
            burst_left_d = burst_size(ctrl_xfer_beats);
            state_d      = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (push) in_left_d = in_left_q - 1'b1;
        if (pop) begin
          out_left_d = out_left_q - 1'b1;
          if (burst_left_q == ONE_BEAT) burst_left_d = burst_size(out_left_q - 1'b1);
          else                          burst_left_d = burst_left_q - 1'b1;
          if (out_left_q == ONE_BEAT) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_left_q    <= '0;
      out_left_q   <= '0;
      burst_left_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_left_q    <= in_left_d;
      out_left_q   <= out_left_d;
      burst_left_q <= burst_left_d;
      done_q       <= done_d;
    end
  end

  hbm_wbuf_fifo #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_DEPTH      (C_FIFO_DEPTH)
  ) u_wbuf (
    .clk       (aclk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (s_axis_tdata),
    .pop       (pop),
    .pop_data  (m_wdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_hbm_wdata_stager.sv
// tb/tb_hbm_wdata_stager.sv - self-checking bench for hbm_wdata_stager
module tb_hbm_wdata_stager;

  localparam int DW    = 512;
  localparam int BL    = 64;
  localparam int DEPTH = 128;
  localparam int LW    = 32;
  localparam int OW    = 8;

  logic          aclk;
  logic          areset_n;
  logic          ctrl_start;
  logic [LW-1:0] ctrl_xfer_beats;
  logic          ctrl_done;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          m_wvalid;
  logic          m_wready;
  logic [DW-1:0] m_wdata;
  logic [OW-1:0] occupancy;
  logic          busy;

  hbm_wdata_stager #(
    .C_DATA_WIDTH (DW),
    .C_BURST_LEN  (BL),
    .C_FIFO_DEPTH (DEPTH),
    .C_LEN_WIDTH  (LW)
  ) dut (
    .aclk            (aclk),
    .areset_n        (areset_n),
    .ctrl_start      (ctrl_start),
    .ctrl_xfer_beats (ctrl_xfer_beats),
    .ctrl_done       (ctrl_done),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .m_wvalid        (m_wvalid),
    .m_wready        (m_wready),
    .m_wdata         (m_wdata),
    .occupancy       (occupancy),
    .busy            (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // Reference model: transfer bookkeeping as plain counts plus a data queue.
  bit            m_running, m_done_pend;
  int            m_total, m_pushed, m_popped;
  logic [DW-1:0] m_q[$];

  int  obs_acc, obs_wr, obs_done, obs_max_occ;
  int  open_occ[$];
  bit  saw_full, saw_resume;

  typedef struct {
    int beats;
    int tv_period;
    int wr_mode;
    int tail;
    int exp_acc;
    int exp_wr;
    int exp_done;
    int exp_max_occ;
    int exp_open0;
    int exp_open1;
    int exp_resume;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int open_at(input int idx);
    return (open_occ.size() > idx) ? open_occ[idx] : -1;
  endfunction

  task automatic model_reset();
    m_running   = 0;
    m_done_pend = 0;
    m_total     = 0;
    m_pushed    = 0;
    m_popped    = 0;
    m_q.delete();
  endtask

  task automatic tick();
    int            occ_m, bstart, blen, rem;
    bit            e_tready, e_wvalid, pushm, popm;
    logic [11:0]   exp_v, act_v;
    logic [DW-1:0] exp_d;
    @(negedge aclk);
    occ_m    = m_pushed - m_popped;
    e_tready = m_running && (occ_m < DEPTH) && (m_pushed < m_total);
    bstart   = (m_popped / BL) * BL;
    blen     = (m_total - bstart < BL) ? (m_total - bstart) : BL;
    rem      = blen - (m_popped - bstart);
    e_wvalid = m_running && (m_popped < m_total) && (occ_m >= rem);
    exp_v = {m_running, e_tready, e_wvalid, m_done_pend, 8'(occ_m)};
    act_v = {busy, s_axis_tready, m_wvalid, ctrl_done, occupancy};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs {busy,tready,wvalid,done,occ}: got %b expected %b at %0t", act_v, exp_v, $time);
    end
    if (s_axis_tvalid && s_axis_tready) obs_acc++;
    if (m_wvalid && m_wready) begin
      if (obs_wr % BL == 0) open_occ.push_back(int'(occupancy));
      obs_wr++;
    end
    if (ctrl_done) obs_done++;
    if (int'(occupancy) > obs_max_occ) obs_max_occ = int'(occupancy);
    if (int'(occupancy) == DEPTH && !s_axis_tready) saw_full = 1;
    if (saw_full && int'(occupancy) == DEPTH-1 && s_axis_tready) saw_resume = 1;

    pushm = s_axis_tvalid && e_tready;
    popm  = e_wvalid && m_wready;
    if (popm && m_q.size() > 0) begin
      exp_d = m_q.pop_front();
      checks++;
      if (m_wdata !== exp_d) begin
        errors++;
        $display("FAIL wdata: got %h expected %h", m_wdata, exp_d);
      end
    end
    if (pushm) m_q.push_back(s_axis_tdata);
    m_done_pend = 0;
    if (m_running) begin
      m_pushed += int'(pushm);
      m_popped += int'(popm);
      if (m_popped == m_total) begin
        m_running   = 0;
        m_done_pend = 1;
      end
    end else if (ctrl_start) begin
      if (ctrl_xfer_beats == '0) begin
        m_done_pend = 1;
      end else begin
        m_running = 1;
        m_total   = int'(ctrl_xfer_beats);
        m_pushed  = 0;
        m_popped  = 0;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input int n, input int tv_period, input int wr_mode, input bit rand_starts);
    s_axis_tvalid = (tv_period == 0) ? ($urandom_range(0, 1) == 1) : (n % tv_period == 0);
    case (wr_mode)
      0:       m_wready = (n >= 150);
      1:       m_wready = 1'b1;
      default: m_wready = ($urandom_range(0, 1) == 1);
    endcase
    s_axis_tdata = rand_data();
    if (rand_starts && m_running && $urandom_range(0, 15) == 0) begin
      ctrl_start      = 1'b1;
      ctrl_xfer_beats = $urandom_range(0, 400);
    end else begin
      ctrl_start = 1'b0;
    end
  endtask

  task automatic run_xfer(input int beats, input int tv_period, input int wr_mode,
                          input int tail, input int stop_after, input bit rand_starts);
    int n;
    bit done_seen;
    obs_acc = 0; obs_wr = 0; obs_done = 0; obs_max_occ = 0;
    open_occ.delete();
    saw_full = 0; saw_resume = 0;
    ctrl_start      = 1'b1;
    ctrl_xfer_beats = beats;
    s_axis_tvalid   = 1'b0;
    m_wready        = 1'b0;
    tick();
    ctrl_start      = 1'b0;
    ctrl_xfer_beats = $urandom;
    n = 0;
    done_seen = 0;
    while (!done_seen && n < 6000) begin
      drive(n, tv_period, wr_mode, rand_starts);
      tick();
      n++;
      if (obs_done > 0) done_seen = 1;
      if (stop_after > 0 && obs_acc >= stop_after) return;
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no ctrl_done within %0d cycles for %0d beats", n, beats);
    end
    for (int i = 0; i < tail; i++) begin
      drive(n + i, tv_period, wr_mode, 1'b0);
      tick();
    end
    s_axis_tvalid = 1'b0;
    m_wready      = 1'b0;
    ctrl_start    = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    vt[0] = '{128, 1, 1,   5, 128, 128, 1,  64,  64,  64, 0};
    vt[1] = '{ 70, 3, 1,   5,  70,  70, 1,  64,  64,   6, 0};
    vt[2] = '{200, 1, 0,   5, 200, 200, 1, 128, 128, 127, 1};
    vt[3] = '{  0, 1, 1,   5,   0,   0, 1,   0,  -1,  -1, 0};
    vt[4] = '{ 10, 1, 1, 300,  10,  10, 1,  10,  10,  -1, 0};

    areset_n        = 1'b1;
    ctrl_start      = 1'b0;
    ctrl_xfer_beats = '0;
    s_axis_tvalid   = 1'b0;
    s_axis_tdata    = '0;
    m_wready        = 1'b0;
    #2 areset_n = 1'b0;
    @(posedge aclk);
    #1;
    model_reset();
    repeat (3) tick();
    areset_n = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 5; i++) begin
      run_xfer(vt[i].beats, vt[i].tv_period, vt[i].wr_mode, vt[i].tail, 0, 1'b0);
      check($sformatf("vec%0d_accepted", i), obs_acc, vt[i].exp_acc);
      check($sformatf("vec%0d_written", i), obs_wr, vt[i].exp_wr);
      check($sformatf("vec%0d_done_pulses", i), obs_done, vt[i].exp_done);
      check($sformatf("vec%0d_max_occupancy", i), obs_max_occ, vt[i].exp_max_occ);
      check($sformatf("vec%0d_burst0_open_occ", i), open_at(0), vt[i].exp_open0);
      check($sformatf("vec%0d_burst1_open_occ", i), open_at(1), vt[i].exp_open1);
      check($sformatf("vec%0d_tready_resume", i), int'(saw_resume), vt[i].exp_resume);
    end

    // Reset in the middle of a transfer, then a fresh short transfer.
    run_xfer(128, 1, 1, 0, 40, 1'b0);
    check("midreset_accepted_before", obs_acc, 40);
    #2 areset_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({busy, s_axis_tready, m_wvalid, ctrl_done, occupancy}), 0);
    model_reset();
    s_axis_tvalid = 1'b0;
    m_wready      = 1'b0;
    obs_done      = 0;
    repeat (3) tick();
    check("no_done_after_reset", obs_done, 0);
    areset_n = 1'b1;
    repeat (3) tick();
    run_xfer(5, 1, 1, 5, 0, 1'b0);
    check("post_reset_accepted", obs_acc, 5);
    check("post_reset_written", obs_wr, 5);
    check("post_reset_done", obs_done, 1);

    // Randomised transfers with random stalls and ignored restarts.
    for (int r = 0; r < 6; r++) begin
      beats = $urandom_range(1, 300);
      run_xfer(beats, 0, 2, 5, 0, 1'b1);
      check($sformatf("rand%0d_accepted", r), obs_acc, beats);
      check($sformatf("rand%0d_written", r), obs_wr, beats);
      check($sformatf("rand%0d_done", r), obs_done, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hbm_wdata_stager.md
HBM_WDATA_STAGER -- requirements
Module: hbm_wdata_stager

Interface
REQ-001 SHALL take parameter C_DATA_WIDTH, default 512, as the stream and AXI write-data width in bits.
REQ-002 SHALL take parameter C_BURST_LEN, default 64, as the beats per full AXI burst (4096 B / 64 B).
REQ-003 SHALL take parameter C_FIFO_DEPTH, default 128, as the buffer depth in beats; must be a power of 2 and at least C_BURST_LEN.
REQ-004 SHALL take parameter C_LEN_WIDTH, default 32, as the beat-count width.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port areset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port ctrl_start, input, 1 bit: one-cycle pulse that starts a transfer.
REQ-008 SHALL have port ctrl_xfer_beats, input, C_LEN_WIDTH bits: total beats, sampled on ctrl_start.
REQ-009 SHALL have port ctrl_done, output, 1 bit: one-cycle pulse after the last beat leaves.
REQ-010 SHALL have port s_axis_tvalid, input, 1 bit: upstream (CGRA) data valid.
REQ-011 SHALL have port s_axis_tready, output, 1 bit: stager accepts a beat.
REQ-012 SHALL have port s_axis_tdata, input, C_DATA_WIDTH bits: upstream data.
REQ-013 SHALL have port m_wvalid, output, 1 bit: beat offered to the write master's data channel.
REQ-014 SHALL have port m_wready, input, 1 bit: write master accepts the beat.
REQ-015 SHALL have port m_wdata, output, C_DATA_WIDTH bits: write data.
REQ-016 SHALL have port occupancy, output, $clog2(C_FIFO_DEPTH)+1 bits: beats currently buffered.
REQ-017 SHALL have port busy, output, 1 bit: high while not in IDLE.

Function
REQ-018 SHALL implement states IDLE and RUN.
REQ-019 IDLE SHALL drive s_axis_tready=0 and m_wvalid=0.
REQ-020 ctrl_start in IDLE with ctrl_xfer_beats>0 SHALL load in_left=out_left=beats and burst_left=min(C_BURST_LEN, beats), then go to RUN next cycle.
REQ-021 ctrl_start with ctrl_xfer_beats=0 SHALL pulse ctrl_done one cycle later and remain IDLE.
REQ-022 ctrl_start while in RUN SHALL be ignored; no reload and no state change.
REQ-023 In RUN, s_axis_tready SHALL be (occupancy<C_FIFO_DEPTH) & (in_left>0); each accepted beat (tvalid&tready) pushes the FIFO and decrements in_left.
REQ-024 Beats beyond ctrl_xfer_beats SHALL never be accepted; tready stays 0 once in_left=0.
REQ-025 The burst gate SHALL open when occupancy>=burst_left and close once burst_left reaches 0; m_wvalid SHALL equal gate_open.
REQ-026 With the gate open, no gaps SHALL occur: m_wvalid stays high until the burst completes, regardless of upstream stalls.
REQ-027 Each beat accepted downstream (m_wvalid&m_wready) SHALL pop the FIFO and decrement burst_left and out_left.
REQ-028 When burst_left reaches 0 with out_left>0, burst_left SHALL reload with min(C_BURST_LEN, out_left) and the gate re-evaluates from the next cycle.
REQ-029 m_wvalid and m_wdata SHALL stay stable while m_wvalid=1 and m_wready=0.
REQ-030 Latency: a beat pushed in cycle N SHALL be presentable on m_wdata no earlier than cycle N+1 (show-ahead FIFO).
REQ-031 Simultaneous push and pop SHALL leave occupancy unchanged; push is blocked at full and pop is impossible at empty.
REQ-032 When out_left reaches 0, ctrl_done SHALL pulse in the following cycle and the state returns to IDLE; occupancy is then 0.
REQ-033 Counters SHALL use C_LEN_WIDTH bits and never wrap below 0.

Reset
REQ-034 Asserting areset_n=0 SHALL immediately force IDLE, s_axis_tready=0, m_wvalid=0, ctrl_done=0, busy=0 and occupancy=0, and zero all counters and FIFO pointers; m_wdata is don't-care.
REQ-035 Reset mid-transfer SHALL discard buffered data with no ctrl_done; release SHALL be synchronised so the first active edge is clean.

Structure
REQ-036 Package hbm_wdata_stager_pkg SHALL hold the state enum and default parameter constants.
REQ-037 The FIFO SHALL be a sub-module, hbm_wbuf_fifo: show-ahead, LUTRAM, with full/empty and count outputs.

Verification
REQ-038 Scenario: start with 128 beats, continuous tvalid, m_wready=1 -> two 64-beat bursts, each with m_wvalid high for exactly 64 cycles, then ctrl_done 1 cycle after the last beat.
REQ-039 Scenario: start with 70 beats, 1 beat upstream every 3 cycles -> m_wvalid stays 0 until occupancy=64, then 64 gapless beats; the second burst of 6 opens at occupancy=6.
REQ-040 Scenario: start with 200 beats, m_wready=0 -> tready drops when occupancy=128 and resumes at 127 after one pop; data order is preserved.
REQ-041 Scenario: ctrl_xfer_beats=0 -> ctrl_done after 1 cycle; tready and m_wvalid stay 0.
REQ-042 Scenario: 300 extra tvalid beats after a 10-beat start -> exactly 10 accepted, 10 written, then ctrl_done.
REQ-043 Scenario: areset_n low after 40 of 128 beats -> outputs 0 asynchronously; a new 5-beat start completes correctly.
